// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared encodings for the multi-cycle hazard unit.
// Contents:
//   FWD_*            forwarding mux selects for the E-stage operand muxes
//   RESULT_SRC_LOAD  ResultSrcE encoding that identifies a load in E
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Per-register pending-write bits for in-flight MDU ops and an occupancy
// counter for the MDU.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   setEn, setIdx     mark register setIdx as awaiting an MDU result
//   clrEn, clrIdx     MDU result for register clrIdx has been written back
//   issue             an MDU op was accepted this cycle (count up)
//   done              an MDU op completed this cycle (count down)
//   Pending           one bit per architectural register
//   full              MDU holds MDU_DEPTH ops
module hazard_scoreboard #(
    parameter int NREG      = 32,
    parameter int REGW      = $clog2(NREG),
    parameter int MDU_DEPTH = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            setEn,
    input  logic [REGW-1:0] setIdx,
    input  logic            clrEn,
    input  logic [REGW-1:0] clrIdx,
    input  logic            issue,
    input  logic            done,
    output logic [NREG-1:0] Pending,
    output logic            full
);

    localparam int CNTW = (MDU_DEPTH < 1) ? 1 : $clog2(MDU_DEPTH + 1);

    logic [CNTW-1:0] cnt;
    logic [NREG-1:0] pendingNext;

    // Clear first so that a coincident set on the same index wins.
    always_comb begin
        pendingNext = Pending;
        if (clrEn) pendingNext[clrIdx] = 1'b0;
        if (setEn) pendingNext[setIdx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Pending <= '0;
            cnt     <= '0;
        end else begin
            Pending <= pendingNext;
            if (issue && !done) begin
                cnt <= cnt + CNTW'(1);
            end else if (done && !issue && cnt != '0) begin
                // A completion with nothing outstanding (op issued before
                // reset) saturates at zero instead of wrapping.
                cnt <= cnt - CNTW'(1);
            end
        end
    end

    assign full = (cnt == CNTW'(MDU_DEPTH));

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
// Hazard controller for the five-stage core with a multi-cycle MDU in E:
// operand forwarding, load-use stall, branch flush, RAW stall against
// in-flight MDU results, and E-stage hold when the MDU is full or the op
// would overwrite a register still awaiting an earlier MDU result.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   Rs1D, Rs2D                      D-stage source registers
//   Rs1E, Rs2E, RdE                 E-stage sources / destination
//   RdM, RdW                        M / W destinations
//   PCSrcE                          taken branch/jump resolved in E
//   ResultSrcE                      E result source (01 = load)
//   RegWriteM, RegWriteW            register write pending in M / W
//   LongOpE                         E holds an MDU op writing RdE
//   LongDoneW, LongRdW              MDU writeback this cycle and its target
//   StallF, StallD, StallE          hold stage registers
//   FlushD, FlushE, FlushM          bubble into stage registers
//   ForwardAE, ForwardBE            operand forwarding selects
//   LongIssue                       MDU accepts the E op this cycle
//   Pending                         scoreboard state (debug)
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int REGW      = $clog2(NREG),
    parameter int MDU_DEPTH = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] Rs1E,
    input  logic [REGW-1:0] Rs2E,
    input  logic [REGW-1:0] RdE,
    input  logic [REGW-1:0] RdM,
    input  logic [REGW-1:0] RdW,
    input  logic            PCSrcE,
    input  logic [1:0]      ResultSrcE,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic            LongOpE,
    input  logic            LongDoneW,
    input  logic [REGW-1:0] LongRdW,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            FlushD,
    output logic            FlushE,
    output logic            FlushM,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            LongIssue,
    output logic [NREG-1:0] Pending
);

    logic full;
    logic lwStall;
    logic scbStall;
    logic structStall;
    logic dStall;

    always_comb begin
        ForwardAE = FWD_RF;
        if (Rs1E != '0 && RegWriteM && Rs1E == RdM)      ForwardAE = FWD_M;
        else if (Rs1E != '0 && RegWriteW && Rs1E == RdW) ForwardAE = FWD_W;

        ForwardBE = FWD_RF;
        if (Rs2E != '0 && RegWriteM && Rs2E == RdM)      ForwardBE = FWD_M;
        else if (Rs2E != '0 && RegWriteW && Rs2E == RdW) ForwardBE = FWD_W;
    end

    assign lwStall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                     ((Rs1D == RdE) || (Rs2D == RdE));

    // No bypass from the MDU writeback: a reader waits until the bit clears
    // and then reads the register file.
    assign scbStall = ((Rs1D != '0) && Pending[Rs1D]) ||
                      ((Rs2D != '0) && Pending[Rs2D]);

    // Hold the MDU op in E when the unit is full or when it would race an
    // older in-flight op to the same destination (WAW).
    assign structStall = LongOpE && (full || ((RdE != '0) && Pending[RdE]));

    // D is on the wrong path when E redirects, so it never needs to wait.
    assign dStall = (lwStall || scbStall) && !PCSrcE;

    assign StallF    = dStall || structStall;
    assign StallD    = dStall || structStall;
    assign StallE    = structStall;
    assign FlushM    = structStall;
    assign FlushD    = PCSrcE;
    // A held E instruction must survive, so the D-stall bubble is only
    // inserted when E advances.
    assign FlushE    = PCSrcE || (dStall && !structStall);
    assign LongIssue = LongOpE && !structStall;

    hazard_scoreboard #(
        .NREG      (NREG),
        .REGW      (REGW),
        .MDU_DEPTH (MDU_DEPTH)
    ) uScoreboard (
        .clk     (clk),
        .reset   (reset),
        .setEn   (LongIssue && (RdE != '0)),
        .setIdx  (RdE),
        .clrEn   (LongDoneW && (LongRdW != '0)),
        .clrIdx  (LongRdW),
        .issue   (LongIssue),
        .done    (LongDoneW),
        .Pending (Pending),
        .full    (full)
    );

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Pipeline hazard controller for the five-stage RISC-V core, and successor to the current single-cycle-execute hazard unit. It is generalised to a parametrised register count and to a multi-cycle execute unit (MDU: mul/div) with up to `MDU_DEPTH` operations in flight. It keeps the existing forwarding, load-use and branch-flush behaviour. It adds a per-register pending-write scoreboard, an MDU occupancy counter, and the E-stage hold and M-stage bubble these require.

## Interface
Parameters:
- `NREG`, 32, architectural register count; register 0 is hard-wired zero.
- `REGW`, `$clog2(NREG)`, register-index width.
- `MDU_DEPTH`, 1, maximum outstanding MDU ops (≥1).

Ports (clock and reset first):
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `Rs1D`, `Rs2D` in REGW: D-stage source registers.
- `Rs1E`, `Rs2E`, `RdE` in REGW: E-stage sources and destination.
- `RdM`, `RdW` in REGW: M and W destinations.
- `PCSrcE` in 1: taken branch/jump resolved in E.
- `ResultSrcE` in 2: `2'b01` = load in E.
- `RegWriteM`, `RegWriteW` in 1: register writes pending in M and W.
- `LongOpE` in 1: E holds an MDU op writing `RdE`.
- `LongDoneW` in 1: MDU result writes back this cycle; the core guarantees `RegWriteW=1` and `RdW=LongRdW` in that cycle.
- `LongRdW` in REGW: destination of the completing MDU op.
- `StallF`, `StallD`, `StallE` out 1: hold stage registers.
- `FlushD`, `FlushE`, `FlushM` out 1: bubble into stage registers.
- `ForwardAE`, `ForwardBE` out 2: `00` = register file, `01` = W result, `10` = M ALU result.
- `LongIssue` out 1: MDU accepts the E-stage op this cycle.
- `Pending` out NREG: scoreboard state, for debug and verification.

## Operation
- **Forwarding** (combinational), per source X∈{1,2} of E:
  - `10` if `RsXE!=0 && RegWriteM && RsXE==RdM`;
  - else `01` if `RsXE!=0 && RegWriteW && RsXE==RdW`;
  - else `00`.
  - M has priority over W.
- **`lwStall`** = `ResultSrcE==2'b01 && RdE!=0 && (Rs1D==RdE || Rs2D==RdE)`.
- **`scbStall`** = `(Rs1D!=0 && Pending[Rs1D]) || (Rs2D!=0 && Pending[Rs2D])`. It is conservative: no bypass in the `LongDoneW` cycle.
- **`structStall`** = `LongOpE && (cnt==MDU_DEPTH || (RdE!=0 && Pending[RdE]))`. This covers both full capacity and a WAW hazard.
- **`dStall`** = `(lwStall || scbStall) && !PCSrcE`. Wrong-path D instructions never stall.
- **Outputs:**
  - `StallF = StallD = dStall || structStall`
  - `StallE = structStall`
  - `FlushM = structStall`
  - `FlushD = PCSrcE`
  - `FlushE = PCSrcE || (dStall && !structStall)`. A held E instruction is never flushed.
  - `LongIssue = LongOpE && !structStall`
- **Scoreboard:**
  - On `LongIssue && RdE!=0`: set `Pending[RdE]`.
  - On `LongDoneW && LongRdW!=0`: clear `Pending[LongRdW]`.
  - A set and a clear on the same index in the same cycle cannot occur, because of the WAW stall. If one is forced anyway, set wins.
- **Counter `cnt`** (range 0..MDU_DEPTH):
  - `+1` on `LongIssue`, `-1` on `LongDoneW`; both together leave it unchanged.
  - `LongDoneW` at `cnt==0` holds `cnt` at 0 (saturate, no wrap).
- **Reset:** `Pending=0`, `cnt=0`. Combinational outputs then follow from the inputs with cleared state. A `LongDoneW` from an op issued before reset is ignored (saturation; clearing an already-clear bit is a no-op).

## Timing
- Forwarding and stall/flush outputs are combinational from inputs and state; zero latency.
- State is registered: a `Pending` bit set by issue in cycle N is visible to `scbStall` in N+1.
- A `Pending` bit cleared by `LongDoneW` in N releases a dependent D instruction in N+1, which then reads the written register file.
- An MDU op held by `structStall` re-evaluates every cycle and issues in the first cycle `cnt<MDU_DEPTH` and the WAW condition are clear.

## Structure
- `hazard_pkg` holds:
  - `FWD_RF=2'b00`, `FWD_W=2'b01`, `FWD_M=2'b10`
  - `RESULT_SRC_LOAD=2'b01`
- Sub-module `hazard_scoreboard` (params `NREG`, `REGW`, `MDU_DEPTH`) contains the `Pending` vector and the `cnt` counter. Its outputs are `Pending` and `full` (`cnt==MDU_DEPTH`).
- Forwarding and stall logic stays in the top module.

## Test plan
- **Forwarding priority:** `Rs1E=5`, `RdM=5`, `RegWriteM=1`, `RdW=5`, `RegWriteW=1` -> `ForwardAE=10`. Then `RegWriteM=0` -> `01`. Then `Rs1E=0` -> `00`.
- **Load-use:** `ResultSrcE=01`, `RdE=7`, `Rs2D=7` -> `StallF=StallD=FlushE=1`, `StallE=0`. Add `PCSrcE=1` -> `StallF=StallD=0`, `FlushD=FlushE=1`.
- **Scoreboard RAW:** MDU op on x9 issues in cycle 0 (`LongIssue=1`). `Rs1D=9` in cycles 1–4 -> stall and `FlushE` each cycle. `LongDoneW=1`, `LongRdW=9` in cycle 4 -> `Pending[9]=0`, no stall in cycle 5.
- **Capacity** (`MDU_DEPTH=1`): second MDU op in E while `cnt=1` -> `StallE=FlushM=StallF=StallD=1`, `LongIssue=0`. Issues the cycle after `LongDoneW`.
- **WAW** (`MDU_DEPTH=2`): second MDU op to the same `Rd` while pending -> `structStall` until the first completes. To a different `Rd` -> issues immediately, `cnt=2`.
- **Reset mid-operation:** `reset` with `Pending[3]=1`, `cnt=1` -> next cycle `Pending=0`, `cnt=0`. A later stray `LongDoneW` leaves `cnt=0`.
